// File: rtl/pixel_pkg.sv
// Shared constants and types for the pixel readout capture path.
package pixel_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int ROW_BYTES      = 4;

  typedef struct packed {
    logic                      first;
    logic                      last;
    logic [DEFAULT_DATA_W-1:0] data;
  } fifoEntry_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_R1 = 2'd1,
    WAIT_R2 = 2'd2
  } fsmState_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous first-word-fall-through FIFO of tagged stream entries.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module byte_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrEn,
  input  fifoEntry_t               wrData,
  input  logic                     rdEn,
  output fifoEntry_t               rdData,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fifoEntry_t  mem [DEPTH];
  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  logic        full;
  logic        doWrite;
  logic        doRead;

  assign empty   = (wrPtr == rdPtr);
  assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count   = wrPtr - rdPtr;
  assign doWrite = wrEn && !full;
  assign doRead  = rdEn && !empty;
  assign rdData  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Storage needs no reset; emptiness is decided by the pointers alone.
  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr[AW-1:0]] <= wrData;
  end

endmodule

// File: rtl/pixel_readout_buffer.sv
// Captures controller pixel rows on read1/read2 falling edges, queues them
// as tagged bytes and streams them out on a valid/ready interface.
module pixel_readout_buffer
  import pixel_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              erase,
  input  logic              read1,
  input  logic              read2,
  input  logic [DATA_W-1:0] pix_in1,
  input  logic [DATA_W-1:0] pix_in2,
  input  logic [DATA_W-1:0] pix_in3,
  input  logic [DATA_W-1:0] pix_in4,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first,
  output logic              out_last,
  output logic              overflow,
  output logic [15:0]       frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(ROW_BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(ROW_BYTES - 1);

  fsmState_t stateQ;
  fsmState_t stateNext;

  logic eraseQ, read1Q, read2Q;
  logic eraseRise, read1Fall, read2Fall;

  logic captureEn, commitReq, commitRow2;
  logic roomOk, commitOk;

  logic [ROW_BYTES-1:0][DATA_W-1:0] holdReg;
  logic [ROW_BYTES-1:0][DATA_W-1:0] pushBuf;
  logic                             pushActive;
  logic [IW-1:0]                    pushIdx;
  logic                             pushRow2;
  logic                             rowDone;

  logic        fifoWrEn;
  fifoEntry_t  fifoWrData;
  fifoEntry_t  fifoRdData;
  logic        fifoEmpty;
  logic [AW:0] fifoCount;
  logic [AW:0] freeSlots;

  assign eraseRise = erase && !eraseQ;
  assign read1Fall = !read1 && read1Q;
  assign read2Fall = !read2 && read2Q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eraseQ <= 1'b0;
      read1Q <= 1'b0;
      read2Q <= 1'b0;
      stateQ <= IDLE;
    end else begin
      eraseQ <= erase;
      read1Q <= read1;
      read2Q <= read2;
      stateQ <= stateNext;
    end
  end

  // Erase wins over a coinciding read edge: the frame restarts cleanly.
  always_comb begin
    stateNext  = stateQ;
    captureEn  = 1'b0;
    commitReq  = 1'b0;
    commitRow2 = 1'b0;
    unique case (stateQ)
      IDLE: captureEn = 1'b0;
      WAIT_R1: begin
        captureEn = read1;
        if (read1Fall) begin
          commitReq = 1'b1;
          stateNext = WAIT_R2;
        end
      end
      WAIT_R2: begin
        captureEn = read2;
        if (read2Fall) begin
          commitReq  = 1'b1;
          commitRow2 = 1'b1;
          stateNext  = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (eraseRise) begin
      stateNext = WAIT_R1;
      captureEn = 1'b0;
      commitReq = 1'b0;
    end
  end

  assign freeSlots = (AW+1)'(DEPTH) - fifoCount;
  assign roomOk    = freeSlots >= (AW+1)'(ROW_BYTES);
  assign commitOk  = commitReq && roomOk && !pushActive;
  assign rowDone   = pushActive && (pushIdx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdReg <= '0;
    end else if (captureEn) begin
      holdReg <= {pix_in4, pix_in3, pix_in2, pix_in1};
    end
  end

  // The row is copied out so the next capture cannot disturb bytes in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pushBuf    <= '0;
      pushActive <= 1'b0;
      pushIdx    <= '0;
      pushRow2   <= 1'b0;
    end else if (commitOk) begin
      pushBuf    <= holdReg;
      pushActive <= 1'b1;
      pushIdx    <= '0;
      pushRow2   <= commitRow2;
    end else if (pushActive) begin
      pushIdx <= pushIdx + 1'b1;
      if (pushIdx == LAST_IDX) pushActive <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (eraseRise)                  overflow <= 1'b0;
      else if (commitReq && !commitOk) overflow <= 1'b1;
      if (rowDone && pushRow2) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign fifoWrEn         = pushActive;
  assign fifoWrData.first = pushActive && !pushRow2 && (pushIdx == '0);
  assign fifoWrData.last  = rowDone && pushRow2;
  assign fifoWrData.data  = pushBuf[pushIdx];

  byte_fifo #(
    .DEPTH (DEPTH)
  ) uFifo (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (fifoWrEn),
    .wrData (fifoWrData),
    .rdEn   (out_ready),
    .rdData (fifoRdData),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  assign out_valid = !fifoEmpty;
  assign out_data  = out_valid ? fifoRdData.data  : '0;
  assign out_first = out_valid ? fifoRdData.first : 1'b0;
  assign out_last  = out_valid ? fifoRdData.last  : 1'b0;

endmodule

// File: tb/tb_pixel_readout_buffer.sv
// Directed bench for pixel_readout_buffer: frames, overflow, protocol error,
// mid-push reset and throttled output, checked against hand-built streams.
module tb_pixel_readout_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, erase, read1, read2;
  logic [7:0]  pix_in1, pix_in2, pix_in3, pix_in4;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_first, out_last, overflow;
  logic [15:0] frame_cnt;

  logic randomReady = 1'b0;
  logic readyLevel  = 1'b1;
  logic readyPhase  = 1'b0;
  logic randBit     = 1'b1;

  int assertCount = 0;
  int failCount   = 0;

  logic [9:0] gotQ[$];
  logic [9:0] expQ[$];

  pixel_readout_buffer #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .erase     (erase),
    .read1     (read1),
    .read2     (read2),
    .pix_in1   (pix_in1),
    .pix_in2   (pix_in2),
    .pix_in3   (pix_in3),
    .pix_in4   (pix_in4),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Throttled consumer: ready at least every other cycle.
  always begin
    @(posedge clk);
    #1;
    readyPhase = ~readyPhase;
    randBit    = readyPhase | 1'($urandom_range(0, 1));
  end

  assign out_ready = randomReady ? randBit : readyLevel;

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) gotQ.push_back({out_first, out_last, out_data});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic setPix(input logic [31:0] word);
    pix_in1 = word[31:24];
    pix_in2 = word[23:16];
    pix_in3 = word[15:8];
    pix_in4 = word[7:0];
  endtask

  task automatic doErase();
    erase = 1'b1;
    step(1);
    erase = 1'b0;
  endtask

  // Holds the chosen read line high for n cycles, drops it and stops on the commit edge.
  task automatic applyStimulus(input int which, input logic [31:0] word, input int n);
    setPix(word);
    if (which == 1) read1 = 1'b1; else read2 = 1'b1;
    step(n);
    read1 = 1'b0;
    read2 = 1'b0;
    step(1);
  endtask

  task automatic sendFrame(input logic [31:0] r1, input logic [31:0] r2);
    doErase();
    applyStimulus(1, r1, 3);
    step(5);
    applyStimulus(2, r2, 3);
    step(5);
  endtask

  task automatic expectFrame(input logic [31:0] r1, input logic [31:0] r2);
    expQ.push_back({2'b10, r1[31:24]});
    expQ.push_back({2'b00, r1[23:16]});
    expQ.push_back({2'b00, r1[15:8]});
    expQ.push_back({2'b00, r1[7:0]});
    expQ.push_back({2'b00, r2[31:24]});
    expQ.push_back({2'b00, r2[23:16]});
    expQ.push_back({2'b00, r2[15:8]});
    expQ.push_back({2'b01, r2[7:0]});
  endtask

  task automatic compareStream(input string tag);
    checkOutput({tag, " count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
      checkOutput($sformatf("%s byte%0d", tag, i), gotQ[i], expQ[i]);
    gotQ.delete();
    expQ.delete();
  endtask

  initial begin
    reset = 1'b1; erase = 1'b0; read1 = 1'b0; read2 = 1'b0;
    setPix(32'h0);
    step(3);
    checkOutput("reset valid", out_valid, 0);
    checkOutput("reset data", out_data, 0);
    checkOutput("reset first", out_first, 0);
    checkOutput("reset last", out_last, 0);
    checkOutput("reset overflow", overflow, 0);
    checkOutput("reset frame_cnt", frame_cnt, 0);
    reset = 1'b0;
    step(2);

    // Basic frame with two-cycle latency after the read1 falling edge.
    doErase();
    applyStimulus(1, 32'h11223344, 3);
    checkOutput("latency early valid", out_valid, 0);
    step(1);
    checkOutput("latency valid", out_valid, 1);
    checkOutput("latency data", out_data, 8'h11);
    checkOutput("latency first", out_first, 1);
    step(4);
    applyStimulus(2, 32'hA1A2A3A4, 3);
    step(6);
    expectFrame(32'h11223344, 32'hA1A2A3A4);
    compareStream("basic");
    checkOutput("basic frame_cnt", frame_cnt, 1);

    // Only the last high cycle's pixels are committed.
    doErase();
    read1 = 1'b1;
    setPix(32'h01010101); step(1);
    setPix(32'h02020202); step(1);
    setPix(32'h03030303); step(1);
    read1 = 1'b0;
    step(6);
    applyStimulus(2, 32'hB1B2B3B4, 3);
    step(6);
    expectFrame(32'h03030303, 32'hB1B2B3B4);
    compareStream("last capture");
    checkOutput("last capture frame_cnt", frame_cnt, 2);

    // A read2 pulse while waiting for read1 must not commit.
    doErase();
    applyStimulus(2, 32'hEEEEEEEE, 2);
    step(5);
    checkOutput("wrong state valid", out_valid, 0);
    checkOutput("wrong state overflow", overflow, 0);
    applyStimulus(1, 32'h31323334, 3);
    step(5);
    applyStimulus(2, 32'h41424344, 3);
    step(6);
    expectFrame(32'h31323334, 32'h41424344);
    compareStream("wrong state");
    checkOutput("wrong state frame_cnt", frame_cnt, 3);

    // Fill the FIFO with the consumer stalled, then a third row is dropped.
    readyLevel = 1'b0;
    sendFrame(32'h50515253, 32'h54555657);
    sendFrame(32'h60616263, 32'h64656667);
    checkOutput("full no overflow", overflow, 0);
    doErase();
    applyStimulus(1, 32'h70717273, 3);
    step(2);
    checkOutput("drop overflow", overflow, 1);
    checkOutput("drop valid", out_valid, 1);
    checkOutput("drop head data", out_data, 8'h50);
    checkOutput("drop head first", out_first, 1);
    checkOutput("drop frame_cnt", frame_cnt, 5);
    step(3);
    checkOutput("stall stable data", out_data, 8'h50);
    checkOutput("sticky overflow", overflow, 1);
    readyLevel = 1'b1;
    step(20);
    expectFrame(32'h50515253, 32'h54555657);
    expectFrame(32'h60616263, 32'h64656667);
    compareStream("full drain");
    doErase();
    step(1);
    checkOutput("erase clears overflow", overflow, 0);

    // Back-to-back frames against a throttled consumer.
    randomReady = 1'b1;
    for (int f = 0; f < 4; f++) begin
      logic [31:0] r1;
      r1 = 32'h80818283 + 32'h10101010 * f;
      sendFrame(r1, r1 ^ 32'h0C0C0C0C);
      expectFrame(r1, r1 ^ 32'h0C0C0C0C);
    end
    randomReady = 1'b0;
    readyLevel  = 1'b1;
    step(20);
    compareStream("throttled");
    checkOutput("throttled overflow", overflow, 0);
    checkOutput("throttled frame_cnt", frame_cnt, 9);

    // Row-2 edge during a push sequence, then reset mid-push.
    readyLevel = 1'b0;
    doErase();
    applyStimulus(1, 32'hC1C2C3C4, 3);
    setPix(32'hD1D2D3D4);
    read2 = 1'b1;
    step(1);
    read2 = 1'b0;
    step(1);
    checkOutput("protocol overflow", overflow, 1);
    checkOutput("protocol valid", out_valid, 1);
    reset = 1'b1;
    step(1);
    checkOutput("midreset valid", out_valid, 0);
    checkOutput("midreset overflow", overflow, 0);
    checkOutput("midreset frame_cnt", frame_cnt, 0);
    reset = 1'b0;
    readyLevel = 1'b1;
    step(2);
    gotQ.delete();
    sendFrame(32'hE1E2E3E4, 32'hF1F2F3F4);
    step(6);
    expectFrame(32'hE1E2E3E4, 32'hF1F2F3F4);
    compareStream("post reset");
    checkOutput("post reset frame_cnt", frame_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
